mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters: none; all widths come from `mycpu_top.h` macros.
REQ-002 clk  in  1  sole clock; all state updates on posedge.
REQ-003 resetn  in  1  reset, asynchronous and active-low.
REQ-004 exe_to_mem_bus  in  `EXE_TO_MEM_BUS_WIDTH` (74)  {alu_result[31:0], res_from_mem, gr_we, dest[4:0], mem_size[1:0], mem_unsigned, exe_pc[31:0]}, MSB first.
REQ-005 exe_to_mem_valid  in  1  upstream holds a valid instruction.
REQ-006 mem_allow_in  out  1  stage can accept this cycle.
REQ-007 wb_allow_in  in  1  downstream can accept.
REQ-008 mem_to_wb_valid  out  1  instruction ready to hand to WB.
REQ-009 mem_to_wb_bus  out  `MEM_TO_WB_BUS_WIDTH` (70)  {final_result[31:0], gr_we, dest[4:0], mem_pc[31:0]}.
REQ-010 mem_to_id_bypass_bus  out  `MEM_TO_ID_BYPASS_WIDTH` (39)  {res_pending, final_result[31:0], gr_we_v, dest[4:0]}.
REQ-011 data_sram_rdata  in  32  load data, meaningful only when data_ok=1.
REQ-012 data_sram_data_ok  in  1  one-cycle pulse: rdata valid for the outstanding load.
REQ-013 mem_valid  out  1  stage occupied (registered), for hazard logic.

Function
REQ-014 mem_size: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-015 Pipeline register SHALL load exe_to_mem_bus only when exe_to_mem_valid && mem_allow_in.
REQ-016 mem_valid SHALL load exe_to_mem_valid when mem_allow_in; otherwise hold.
REQ-017 mem_allow_in = !mem_valid || (mem_ready_go && wb_allow_in); mem_to_wb_valid = mem_valid && mem_ready_go.
REQ-018 FSM states IDLE, WAIT, HOLD; held in a 2-bit register.
REQ-019 IDLE->WAIT when a load (res_from_mem=1) is accepted; non-load acceptance stays/returns IDLE.
REQ-020 WAIT & data_ok & wb_allow_in -> IDLE (or WAIT if a new load is accepted same cycle); WAIT & data_ok & !wb_allow_in -> HOLD, rdata captured into rdata_buf.
REQ-021 HOLD & wb_allow_in -> IDLE/WAIT per incoming instruction; HOLD ignores data_ok.
REQ-022 mem_ready_go = !res_from_mem || (state==WAIT && data_ok) || state==HOLD.
REQ-023 Load data source: data_sram_rdata in WAIT, rdata_buf in HOLD.
REQ-024 Byte load selects byte alu_result[1:0]; half selects half alu_result[1]; extend zero if mem_unsigned else sign; word passes unchanged.
REQ-025 final_result = aligned load data if res_from_mem else alu_result; zero-latency (combinational) through the stage.
REQ-026 Misaligned half/word addresses SHALL use low bits as in REQ-024 (no exception; ignore alu_result[0] for half, [1:0] for word).
REQ-027 gr_we_v = mem_valid && gr_we; res_pending = mem_valid && res_from_mem && !mem_ready_go.
REQ-028 Non-load instruction: one cycle in MEM when wb_allow_in=1; stalls indefinitely otherwise, outputs stable.
REQ-029 data_ok in IDLE, or with mem_valid=0, SHALL be ignored.

Reset
REQ-030 resetn low SHALL asynchronously force mem_valid=0, state=IDLE, rdata_buf=0, pipeline register=0; mem_allow_in=1, mem_to_wb_valid=0, gr_we_v=0, res_pending=0 while low.
REQ-031 Reset mid-WAIT discards the load; a later data_ok is ignored per REQ-029.

Structure
REQ-032 Bus widths and mem_size encodings SHALL be macros in `mycpu_top.h`; FSM state encodings local localparams.
REQ-033 Load alignment/extension SHALL be one combinational sub-module load_align (addr[1:0], size, unsigned, rdata -> result).

Verification
REQ-034 ALU op alu_result=0x1234, gr_we=1, dest=5, wb_allow_in=1 -> next cycle mem_to_wb_valid=1, final_result=0x1234, bypass gr_we_v=1 dest=5.
REQ-035 ld.b addr 0x...3, signed, data_ok next cycle rdata=0x80FF_0000 -> final_result=0xFFFF_FF80; ld.bu -> 0x0000_0080.
REQ-036 ld.h addr 0x...2, data_ok delayed 3 cycles, rdata=0x8001_0000 -> res_pending=1 for 3 cycles, mem_allow_in=0, then final_result=0xFFFF_8001.
REQ-037 ld.w, data_ok with wb_allow_in=0 for 2 cycles, rdata=0xDEADBEEF then bus changes -> state HOLD, final_result stays 0xDEADBEEF, issued when wb_allow_in=1.
REQ-038 resetn low during WAIT, data_ok after release -> mem_valid=0, no mem_to_wb_valid pulse, state IDLE.
REQ-039 Back-to-back loads, data_ok each cycle, wb_allow_in=1 -> one result per cycle, no bubbles, results in order.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, mem_size encodings,
// the decoded EXE->MEM bus layout and the load-extension helpers.
`ifndef MYCPU_TOP_H
`define MYCPU_TOP_H
`define EXE_TO_MEM_BUS_WIDTH   74
`define MEM_TO_WB_BUS_WIDTH    70
`define MEM_TO_ID_BYPASS_WIDTH 39
`define MEM_SIZE_BYTE          2'b00
`define MEM_SIZE_HALF          2'b01
`define MEM_SIZE_WORD          2'b10
`endif

package mem_stage_pkg;

  typedef struct packed {
    logic [31:0] alu_result;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] exe_pc;
  } exe_bus_t;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic is_unsigned);
    logic [31:0] r;
    if (is_unsigned) r = {24'd0, b};
    else             r = {{24{b[7]}}, b};
    return r;
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic is_unsigned);
    logic [31:0] r;
    if (is_unsigned) r = {16'd0, h};
    else             r = {{16{h[15]}}, h};
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed byte/half from the SRAM word and
// extends it; misaligned halves/words simply use the low address bits.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection for byte and half accesses
  always_comb begin
    byte_s = 8'd0;
    case (addr)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = 8'd0;
    endcase
    if (addr[1]) half_s = rdata[31:16];
    else         half_s = rdata[15:0];
  end

  // Size decode; size 11 behaves as a word load
  always_comb begin
    result = rdata;
    case (size)
      `MEM_SIZE_BYTE: result = ext8(byte_s, is_unsigned);
      `MEM_SIZE_HALF: result = ext16(half_s, is_unsigned);
      default:        result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, waits for load data from the
// data SRAM (buffering it if WB stalls) and forwards the result to WB and ID.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                               clk,
  input  logic                               resetn,
  input  logic [`EXE_TO_MEM_BUS_WIDTH-1:0]   exe_to_mem_bus,
  input  logic                               exe_to_mem_valid,
  output logic                               mem_allow_in,
  input  logic                               wb_allow_in,
  output logic                               mem_to_wb_valid,
  output logic [`MEM_TO_WB_BUS_WIDTH-1:0]    mem_to_wb_bus,
  output logic [`MEM_TO_ID_BYPASS_WIDTH-1:0] mem_to_id_bypass_bus,
  input  logic [31:0]                        data_sram_rdata,
  input  logic                               data_sram_data_ok,
  output logic                               mem_valid
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  exe_bus_t    bus_r;
  logic        mem_valid_r;
  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic [31:0] rdata_buf_r;
  logic        ready_go_s;
  logic        allow_in_s;
  logic        accept_load_s;
  logic [31:0] load_data_s;
  logic [31:0] load_result_s;
  logic [31:0] final_result_s;

  // Handshake and result selection
  always_comb begin
    ready_go_s     = !bus_r.res_from_mem
                   || (state_r == ST_WAIT && data_sram_data_ok)
                   || (state_r == ST_HOLD);
    allow_in_s     = !mem_valid_r || (ready_go_s && wb_allow_in);
    accept_load_s  = exe_to_mem_valid && allow_in_s
                   && exe_to_mem_bus[`EXE_TO_MEM_BUS_WIDTH-33];
    if (state_r == ST_HOLD) load_data_s = rdata_buf_r;
    else                    load_data_s = data_sram_rdata;
    if (bus_r.res_from_mem) final_result_s = load_result_s;
    else                    final_result_s = bus_r.alu_result;
  end

  load_align u_load_align (
    .addr        (bus_r.alu_result[1:0]),
    .size        (bus_r.mem_size),
    .is_unsigned (bus_r.mem_unsigned),
    .rdata       (load_data_s),
    .result      (load_result_s)
  );

  // Next state: a departing instruction lets the incoming one pick the state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_load_s) state_nxt_s = ST_WAIT;
        else               state_nxt_s = ST_IDLE;
      end
      ST_WAIT: begin
        if (data_sram_data_ok && wb_allow_in) state_nxt_s = accept_load_s ? ST_WAIT : ST_IDLE;
        else if (data_sram_data_ok)           state_nxt_s = ST_HOLD;
        else                                  state_nxt_s = ST_WAIT;
      end
      ST_HOLD: begin
        if (wb_allow_in) state_nxt_s = accept_load_s ? ST_WAIT : ST_IDLE;
        else             state_nxt_s = ST_HOLD;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state and load-data buffer for a WB stall
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      rdata_buf_r <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_WAIT && data_sram_data_ok && !wb_allow_in) rdata_buf_r <= data_sram_rdata;
    end
  end

  // Pipeline register and occupancy flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid_r <= 1'b0;
      bus_r       <= '0;
    end else begin
      if (allow_in_s) mem_valid_r <= exe_to_mem_valid;
      if (allow_in_s && exe_to_mem_valid) bus_r <= exe_bus_t'(exe_to_mem_bus);
    end
  end

  assign mem_valid            = mem_valid_r;
  assign mem_allow_in         = allow_in_s;
  assign mem_to_wb_valid      = mem_valid_r && ready_go_s;
  assign mem_to_wb_bus        = {final_result_s, bus_r.gr_we, bus_r.dest, bus_r.exe_pc};
  assign mem_to_id_bypass_bus = {mem_valid_r && bus_r.res_from_mem && !ready_go_s,
                                 final_result_s, mem_valid_r && bus_r.gr_we, bus_r.dest};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// traffic, compared every cycle against a one-slot behavioural model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic [73:0] exe_to_mem_bus;
  logic        exe_to_mem_valid;
  logic        mem_allow_in;
  logic        wb_allow_in;
  logic        mem_to_wb_valid;
  logic [69:0] mem_to_wb_bus;
  logic [38:0] mem_to_id_bypass_bus;
  logic [31:0] data_sram_rdata;
  logic        data_sram_data_ok;
  logic        mem_valid;

  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .clk                  (clk),
    .resetn               (resetn),
    .exe_to_mem_bus       (exe_to_mem_bus),
    .exe_to_mem_valid     (exe_to_mem_valid),
    .mem_allow_in         (mem_allow_in),
    .wb_allow_in          (wb_allow_in),
    .mem_to_wb_valid      (mem_to_wb_valid),
    .mem_to_wb_bus        (mem_to_wb_bus),
    .mem_to_id_bypass_bus (mem_to_id_bypass_bus),
    .data_sram_rdata      (data_sram_rdata),
    .data_sram_data_ok    (data_sram_data_ok),
    .mem_valid            (mem_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [73:0] mk(input logic [31:0] alu, input logic ld, input logic we,
                                     input logic [4:0] dest, input logic [1:0] sz,
                                     input logic uns, input logic [31:0] pc);
    return {alu, ld, we, dest, sz, uns, pc};
  endfunction

  // Reference load semantics: shift the addressed lane down, then extend
  function automatic logic [31:0] align(input logic [1:0] a, input logic [1:0] sz,
                                        input logic uns, input logic [31:0] d);
    logic [31:0] sh;
    if (sz == 2'b00) begin
      sh = d >> (8 * int'(a));
      return uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
    end else if (sz == 2'b01) begin
      sh = d >> (16 * int'(a[1]));
      return uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
    end
    return d;
  endfunction

  // Model: one slot holding the resident instruction and any captured data
  logic        m_valid = 1'b0;
  logic        m_got   = 1'b0;
  logic [31:0] m_alu, m_pc, m_data;
  logic        m_load, m_we, m_uns;
  logic [4:0]  m_dest;
  logic [1:0]  m_size;

  function automatic logic m_ready();
    return !m_load || m_got || data_sram_data_ok;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_valid <= 1'b0;
      m_got   <= 1'b0;
    end else if (!m_valid || (m_ready() && wb_allow_in)) begin
      m_valid <= exe_to_mem_valid;
      if (exe_to_mem_valid) begin
        {m_alu, m_load, m_we, m_dest, m_size, m_uns, m_pc} <= exe_to_mem_bus;
        m_got <= 1'b0;
      end
    end else if (m_load && !m_got && data_sram_data_ok) begin
      m_got  <= 1'b1;
      m_data <= data_sram_rdata;
    end
  end

  // Compare process: every negedge while out of reset
  always @(negedge clk) begin
    logic        rdy;
    logic [31:0] fin;
    if (resetn === 1'b1) begin
      rdy = m_ready();
      fin = m_load ? align(m_alu[1:0], m_size, m_uns, m_got ? m_data : data_sram_rdata) : m_alu;
      chk("mem_valid", {31'd0, mem_valid}, {31'd0, m_valid});
      chk("allow_in", {31'd0, mem_allow_in}, {31'd0, !m_valid || (rdy && wb_allow_in)});
      chk("to_wb_valid", {31'd0, mem_to_wb_valid}, {31'd0, m_valid && rdy});
      chk("gr_we_v", {31'd0, mem_to_id_bypass_bus[5]}, {31'd0, m_valid && m_we});
      chk("res_pending", {31'd0, mem_to_id_bypass_bus[38]}, {31'd0, m_valid && m_load && !rdy});
      if (m_valid) begin
        chk("bypass_dest", {27'd0, mem_to_id_bypass_bus[4:0]}, {27'd0, m_dest});
        chk("wb_pc", mem_to_wb_bus[31:0], m_pc);
        chk("wb_we_dest", {26'd0, mem_to_wb_bus[37:32]}, {26'd0, m_we, m_dest});
        if (rdy) begin
          chk("wb_final", mem_to_wb_bus[69:38], fin);
          chk("bypass_final", mem_to_id_bypass_bus[37:6], fin);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [73:0] b, input logic wb,
                     input logic dok, input logic [31:0] rd);
    exe_to_mem_valid  = v;
    exe_to_mem_bus    = b;
    wb_allow_in       = wb;
    data_sram_data_ok = dok;
    data_sram_rdata   = rd;
  endtask

  initial begin
    resetn = 1'b0;
    put(1'b0, 74'd0, 1'b1, 1'b0, 32'd0);
    #12;
    chk("rst_allow", {31'd0, mem_allow_in}, 32'd1);
    chk("rst_to_wb", {31'd0, mem_to_wb_valid}, 32'd0);
    chk("rst_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_pending", {31'd0, mem_to_id_bypass_bus[38]}, 32'd0);
    chk("rst_gr_we_v", {31'd0, mem_to_id_bypass_bus[5]}, 32'd0);
    resetn = 1'b1;
    cyc();

    // ALU op passes through in one cycle
    put(1'b1, mk(32'h1234, 1'b0, 1'b1, 5'd5, 2'b10, 1'b0, 32'h100), 1'b1, 1'b0, 32'd0);
    cyc();
    exe_to_mem_valid = 1'b0;
    @(negedge clk);
    chk("alu_to_wb", {31'd0, mem_to_wb_valid}, 32'd1);
    chk("alu_final", mem_to_wb_bus[69:38], 32'h0000_1234);
    chk("alu_gr_we_v", {31'd0, mem_to_id_bypass_bus[5]}, 32'd1);
    chk("alu_dest", {27'd0, mem_to_id_bypass_bus[4:0]}, 32'd5);
    cyc();

    // ld.b / ld.bu at byte 3
    for (int u = 0; u < 2; u++) begin
      put(1'b1, mk(32'h1003, 1'b1, 1'b1, 5'd7, 2'b00, u[0], 32'h104 + 32'(4 * u)), 1'b1, 1'b0, 32'd0);
      cyc();
      put(1'b0, 74'd0, 1'b1, 1'b1, 32'h80FF_0000);
      @(negedge clk);
      chk(u == 0 ? "ldb_final" : "ldbu_final", mem_to_wb_bus[69:38],
          u == 0 ? 32'hFFFF_FF80 : 32'h0000_0080);
      cyc();
      data_sram_data_ok = 1'b0;
    end

    // ld.h with data three cycles late
    put(1'b1, mk(32'h2002, 1'b1, 1'b1, 5'd9, 2'b01, 1'b0, 32'h10C), 1'b1, 1'b0, 32'd0);
    cyc();
    exe_to_mem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ldh_pending", {31'd0, mem_to_id_bypass_bus[38]}, 32'd1);
      chk("ldh_stall", {31'd0, mem_allow_in}, 32'd0);
      cyc();
    end
    put(1'b0, 74'd0, 1'b1, 1'b1, 32'h8001_0000);
    @(negedge clk);
    chk("ldh_final", mem_to_wb_bus[69:38], 32'hFFFF_8001);
    cyc();
    data_sram_data_ok = 1'b0;

    // ld.w arriving while WB stalls; buffered value must persist
    put(1'b1, mk(32'h3000, 1'b1, 1'b1, 5'd3, 2'b10, 1'b0, 32'h110), 1'b1, 1'b0, 32'd0);
    cyc();
    put(1'b0, 74'd0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("ldw_first", mem_to_wb_bus[69:38], 32'hDEAD_BEEF);
    cyc();
    put(1'b0, 74'd0, 1'b0, 1'b0, 32'h1234_5678);
    @(negedge clk);
    chk("ldw_hold", mem_to_wb_bus[69:38], 32'hDEAD_BEEF);
    cyc();
    wb_allow_in = 1'b1;
    @(negedge clk);
    chk("ldw_issue", mem_to_wb_bus[69:38], 32'hDEAD_BEEF);
    chk("ldw_issue_v", {31'd0, mem_to_wb_valid}, 32'd1);
    cyc();

    // Reset during WAIT, late data_ok must be ignored
    put(1'b1, mk(32'h4000, 1'b1, 1'b1, 5'd4, 2'b10, 1'b0, 32'h120), 1'b1, 1'b0, 32'd0);
    cyc();
    exe_to_mem_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("wrst_valid", {31'd0, mem_valid}, 32'd0);
    chk("wrst_allow", {31'd0, mem_allow_in}, 32'd1);
    chk("wrst_to_wb", {31'd0, mem_to_wb_valid}, 32'd0);
    chk("wrst_pending", {31'd0, mem_to_id_bypass_bus[38]}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    cyc();
    put(1'b0, 74'd0, 1'b1, 1'b1, 32'h5555_AAAA);
    @(negedge clk);
    chk("wrst_late_valid", {31'd0, mem_valid}, 32'd0);
    chk("wrst_late_to_wb", {31'd0, mem_to_wb_valid}, 32'd0);
    cyc();
    data_sram_data_ok = 1'b0;

    // Back-to-back word loads, one result per cycle
    put(1'b1, mk(32'h5000, 1'b1, 1'b1, 5'd1, 2'b10, 1'b0, 32'h200), 1'b1, 1'b0, 32'd0);
    cyc();
    for (int i = 1; i <= 4; i++) begin
      put(i < 4, mk(32'h5000 + 32'(4 * i), 1'b1, 1'b1, 5'(i + 1), 2'b10, 1'b0, 32'h200 + 32'(4 * i)),
          1'b1, 1'b1, 32'hA000_0000 + 32'(i - 1));
      @(negedge clk);
      chk("b2b_to_wb", {31'd0, mem_to_wb_valid}, 32'd1);
      chk("b2b_allow", {31'd0, mem_allow_in}, 32'd1);
      chk("b2b_final", mem_to_wb_bus[69:38], 32'hA000_0000 + 32'(i - 1));
      chk("b2b_pc", mem_to_wb_bus[31:0], 32'h200 + 32'(4 * (i - 1)));
      cyc();
    end
    data_sram_data_ok = 1'b0;

    // Randomized traffic, including stray data_ok pulses
    for (int n = 0; n < 800; n++) begin
      put($urandom_range(0, 1) == 1,
          mk($urandom(), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
             $urandom()),
          $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, $urandom());
      cyc();
    end
    put(1'b0, 74'd0, 1'b1, 1'b1, 32'd0);
    cyc();
    cyc();
    data_sram_data_ok = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
